citadel_key_verifier: RTL and testbench
=======================================

Name: citadel_key_verifier

Overview:
- Parametrised, pipelined successor to the combinational Key Comparator (XNOR bit-compare plus AND reduction).
- Accepts a candidate key over a valid/ready handshake and compares it against a reference key using a registered XNOR stage and a registered radix-4 AND reduction tree.
- Drives grant, deny and lockout outputs from an attempt-limiting FSM.
- Sits between the Sentinel input deserialiser and the unlock/status output pins.

Parameters:
- KEY_WIDTH, 8, key width in bits (2..64).
- MAX_ATTEMPTS, 3, consecutive failed attempts that trigger lockout (1..15).
- GRANT_CYCLES, 4, cycles `unlock` stays high after a match (>=1).
- LOCKOUT_CYCLES, 16, cycles spent in lockout before returning to IDLE (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- key_in  in  KEY_WIDTH  candidate key.
- key_valid  in  1  candidate present.
- key_ready  out  1  block can accept a candidate.
- ref_key  in  KEY_WIDTH  reference key, sampled on accept.
- unlock  out  1  access granted.
- deny  out  1  one-cycle pulse on mismatch.
- locked_out  out  1  lockout active.
- fail_count  out  FCW  consecutive failures, FCW = $clog2(MAX_ATTEMPTS+1).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state IDLE; pipeline registers, counters and fail_count cleared.
  - unlock, deny, locked_out and busy are 0.
  - key_ready is 0 while rst_n is low, and 1 in the first cycle after release.
  - Reset mid-operation aborts any check, grant or lockout with no residual pulse.
- Handshake:
  - key_ready = (state == IDLE) && rst_n.
  - Accept occurs when key_valid && key_ready at a rising edge.
  - On accept, ref_key and key_in are captured; later changes to either are ignored for that attempt.
  - key_valid while not ready is ignored, not queued.
- Pipeline:
  - Stage 0 registers the bitwise XNOR of the two keys.
  - The tree has L = max(1, ceil(log4(KEY_WIDTH))) levels of registered 4-input ANDs.
  - Unused inputs of partial groups are tied to 1.
  - Result latency is 1+L edges after the accepting edge (3 for the default KEY_WIDTH=8).
- FSM states: IDLE, CHECK, GRANT, DENY, LOCKOUT.
  - IDLE -> CHECK on accept.
  - CHECK holds for 1+L cycles, then goes to GRANT on match or DENY on mismatch.
  - GRANT:
    - unlock = 1 for exactly GRANT_CYCLES cycles.
    - fail_count cleared on entry.
    - Then IDLE.
  - DENY:
    - One cycle; deny = 1.
    - fail_count increments, saturating at MAX_ATTEMPTS.
    - If the new count == MAX_ATTEMPTS -> LOCKOUT, else -> IDLE.
  - LOCKOUT:
    - locked_out = 1 for exactly LOCKOUT_CYCLES cycles.
    - fail_count is held at MAX_ATTEMPTS during lockout, then cleared on exit to IDLE.
- Outputs are registered; no combinational path from key_in to unlock or deny.
- Back-to-back operation: a new key can be accepted in the cycle after GRANT, DENY or LOCKOUT exits. Minimum accept-to-accept spacing is 1+L+1 cycles for deny, or 1+L+GRANT_CYCLES for grant.
- fail_count is never wider than FCW bits and never wraps.

Optional Feature:
- Macro: CITADEL_TAMPER_EN.
- Enabled:
  - Adds input port `tamper` (1 bit).
  - tamper = 1 at any rising edge, in any state, forces LOCKOUT on the next cycle.
  - The lockout counter reloads to LOCKOUT_CYCLES and fail_count is forced to MAX_ATTEMPTS.
  - Any in-flight CHECK result is discarded, and unlock drops to 0 on the next edge.
  - tamper held high keeps the block in LOCKOUT, reloading the counter each cycle.
  - tamper has priority over all FSM transitions except reset.
- Disabled: the port is absent and behaviour is as specified above.

Test Plan:
- Reset, then key_in=ref_key=8'hA5 with key_valid for 1 cycle -> unlock=1 from accept+3 for 4 cycles; fail_count=0; key_ready returns 1 afterwards.
- ref_key=8'hA5, key_in=8'h A4 -> deny pulse of 1 cycle at accept+3; fail_count=1; unlock never asserts.
- Three mismatches in a row -> the third deny is followed by locked_out=1 for exactly 16 cycles, with key_ready=0 and key_valid ignored throughout; fail_count=0 after exit.
- Two mismatches, then a match -> unlock for 4 cycles and fail_count returns 0; a subsequent mismatch yields fail_count=1, with no lockout.
- Change ref_key and key_in during CHECK, then assert rst_n=0 for 1 cycle mid-GRANT -> result is unaffected by the change; reset clears unlock, busy and fail_count on the next edge, and key_ready=1 in the first cycle after release.
- With CITADEL_TAMPER_EN, pulse tamper during CHECK of a matching key -> no unlock; locked_out=1 for 16 cycles from the cycle after the pulse.
- KEY_WIDTH=17 (L=3) match -> unlock at accept+4; a single-bit mismatch in bit 16 -> deny.

Source files
------------

// File: rtl/citadel_key_verifier.sv
// citadel_key_verifier
//   Pipelined key verifier: a registered XNOR stage feeds a registered radix-4
//   AND reduction tree, and an attempt-limiting FSM turns the match result into
//   unlock / deny / lockout indications.
//   Optional feature macro: CITADEL_TAMPER_EN adds a `tamper` input that forces
//   an immediate lockout from any state.

module citadel_key_verifier #(
    parameter int KEY_WIDTH      = 8,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int GRANT_CYCLES   = 4,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [KEY_WIDTH-1:0]                  key_in,
    input  logic                                  key_valid,
    output logic                                  key_ready,
    input  logic [KEY_WIDTH-1:0]                  ref_key,
    output logic                                  unlock,
    output logic                                  deny,
    output logic                                  locked_out,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     fail_count,
    output logic                                  busy
`ifdef CITADEL_TAMPER_EN
    ,
    input  logic                                  tamper
`endif
);

    // Number of radix-4 AND levels: smallest L >= 1 with 4**L >= KEY_WIDTH.
    function automatic int calc_levels(input int width);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        while (span < width) begin
            span = span * 4;
            lv++;
        end
        return (lv < 1) ? 1 : lv;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int L       = calc_levels(KEY_WIDTH);
    localparam int PADW    = 1 << (2 * L);
    localparam int FCW     = $clog2(MAX_ATTEMPTS + 1);
    localparam int CNT_MAX = max3(L, GRANT_CYCLES - 1, LOCKOUT_CYCLES - 1);
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Counters are loaded with (duration - 1) and count down to zero.
    localparam logic [CW-1:0]  CHK_INIT   = CW'(L);
    localparam logic [CW-1:0]  GRANT_INIT = CW'(GRANT_CYCLES - 1);
    localparam logic [CW-1:0]  LOCK_INIT  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [FCW-1:0] FC_MAX     = FCW'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_GRANT,
        S_DENY,
        S_LOCKOUT
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic [FCW-1:0]       r_fail;
    logic [FCW-1:0]       w_fail_next;
    logic                 r_unlock;
    logic                 r_deny;
    logic                 r_locked;
    logic                 r_busy;
    logic                 w_accept;
    logic                 w_match;
    logic [KEY_WIDTH-1:0] r_xnor;
    logic [PADW-1:0]      w_pad;

    assign key_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept  = key_valid && key_ready;

    // Stage 0: capture the bitwise equality of both keys on accept only, so
    // later changes on key_in / ref_key cannot disturb an attempt in flight.
    always_ff @(posedge clk) begin
        // NOTE: pipeline registers are reset too, so a reset leaves no stale
        // match result that a later CHECK could pick up.
        if (!rst_n) begin
            r_xnor <= '0;
        end else if (w_accept) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples values from before the clock edge.
            r_xnor <= ~(key_in ^ ref_key);
        end
    end

    // Pad partial groups with ones so they never veto a match.
    generate
        if (PADW > KEY_WIDTH) begin : g_pad
            assign w_pad = {{(PADW - KEY_WIDTH){1'b1}}, r_xnor};
        end else begin : g_nopad
            assign w_pad = r_xnor;
        end
    endgenerate

    // Radix-4 AND reduction tree, one register per level.
    generate
        for (genvar g = 0; g < L; g++) begin : g_lvl
            localparam int IW = 1 << (2 * (L - g));
            localparam int OW = IW / 4;

            logic [IW-1:0] w_in;
            logic [OW-1:0] r_and;

            if (g == 0) begin : g_first
                assign w_in = w_pad;
            end else begin : g_next
                assign w_in = g_lvl[g-1].r_and;
            end

            // Reduce each group of four inputs into one registered bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_and <= '0;
                end else begin
                    for (int j = 0; j < OW; j++) begin
                        r_and[j] <= &w_in[4*j +: 4];
                    end
                end
            end
        end
    endgenerate

    assign w_match = g_lvl[L-1].r_and[0];

    // FSM state, shared duration counter and consecutive-failure counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_fail  <= w_fail_next;
        end
    end

    // Next-state, counter and failure-count logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fail_next  = r_fail;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CHECK;
                    w_cnt_next   = CHK_INIT;
                end
            end
            S_CHECK: begin
                if (r_cnt == '0) begin
                    if (w_match) begin
                        w_state_next = S_GRANT;
                        w_cnt_next   = GRANT_INIT;
                        w_fail_next  = '0;
                    end else begin
                        w_state_next = S_DENY;
                        w_fail_next  = (r_fail == FC_MAX) ? FC_MAX : r_fail + FCW'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_GRANT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_DENY: begin
                if (r_fail == FC_MAX) begin
                    w_state_next = S_LOCKOUT;
                    w_cnt_next   = LOCK_INIT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                w_fail_next = FC_MAX;
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                    w_fail_next  = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

`ifdef CITADEL_TAMPER_EN
        // Tamper overrides every transition and discards any pending result.
        if (tamper) begin
            w_state_next = S_LOCKOUT;
            w_cnt_next   = LOCK_INIT;
            w_fail_next  = FC_MAX;
        end
`endif
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_unlock <= 1'b0;
            r_deny   <= 1'b0;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_unlock <= (w_state_next == S_GRANT);
            r_deny   <= (w_state_next == S_DENY);
            r_locked <= (w_state_next == S_LOCKOUT);
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

    assign unlock     = r_unlock;
    assign deny       = r_deny;
    assign locked_out = r_locked;
    assign busy       = r_busy;
    assign fail_count = r_fail;

endmodule

// File: tb/tb_citadel_key_verifier.sv
// tb_citadel_key_verifier
//   Directed bench for citadel_key_verifier: default 8-bit instance plus a
//   17-bit instance for the three-level tree. Tamper scenario is built only
//   when CITADEL_TAMPER_EN is defined.

module tb_citadel_key_verifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_in;
    logic [7:0] ref_key;
    logic       key_valid;
    logic       key_ready;
    logic       unlock;
    logic       deny;
    logic       locked_out;
    logic [1:0] fail_count;
    logic       busy;
`ifdef CITADEL_TAMPER_EN
    logic       tamper;
`endif

    logic [16:0] k17_in;
    logic [16:0] k17_ref;
    logic        k17_valid;
    logic        k17_ready;
    logic        k17_unlock;
    logic        k17_deny;
    logic        k17_locked;
    logic [1:0]  k17_fail;
    logic        k17_busy;

    int checks = 0;
    int errors = 0;

    // Per-cycle traces of one attempt; bit k holds the value seen after the
    // k-th rising edge following the accepting edge (bit 0 = accepting edge).
    logic [31:0] tr_unl;
    logic [31:0] tr_deny;
    logic [31:0] tr_lock;
    logic [31:0] tr_busy;
    logic [31:0] tr_rdy;
    logic [1:0]  fc3;
    logic [1:0]  fc_mid;
    logic [1:0]  fc_end;

    always #5 clk = ~clk;

    citadel_key_verifier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .ref_key    (ref_key),
        .unlock     (unlock),
        .deny       (deny),
        .locked_out (locked_out),
        .fail_count (fail_count),
        .busy       (busy)
`ifdef CITADEL_TAMPER_EN
        ,
        .tamper     (tamper)
`endif
    );

    citadel_key_verifier #(.KEY_WIDTH(17)) dut17 (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (k17_in),
        .key_valid  (k17_valid),
        .key_ready  (k17_ready),
        .ref_key    (k17_ref),
        .unlock     (k17_unlock),
        .deny       (k17_deny),
        .locked_out (k17_locked),
        .fail_count (k17_fail),
        .busy       (k17_busy)
`ifdef CITADEL_TAMPER_EN
        ,
        .tamper     (1'b0)
`endif
    );

    // Drive one attempt on the 8-bit instance and record traces for n cycles.
    task automatic attempt(input logic [7:0] k, input logic [7:0] r, input int n,
                           input int hold, input bit scramble, input int tamper_at);
        int waited;
        waited = 0;
        @(negedge clk);
        while (key_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: key_ready=%b required 1", key_ready);
        end
        key_in    = k;
        ref_key   = r;
        key_valid = 1'b1;
        tr_unl    = '0;
        tr_deny   = '0;
        tr_lock   = '0;
        tr_busy   = '0;
        tr_rdy    = '0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            tr_unl[i]  = unlock;
            tr_deny[i] = deny;
            tr_lock[i] = locked_out;
            tr_busy[i] = busy;
            tr_rdy[i]  = key_ready;
            if (i == 3) fc3 = fail_count;
            if (i == 12) fc_mid = fail_count;
            fc_end = fail_count;
            key_valid = (i < hold);
            if (scramble && i == 0) begin
                key_in  = ~k;
                ref_key = k ^ 8'h0F;
            end
`ifdef CITADEL_TAMPER_EN
            tamper = (i == tamper_at - 1);
`endif
        end
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = 8'h00;
        ref_key   = 8'h00;
        k17_valid = 1'b0;
        k17_in    = '0;
        k17_ref   = '0;
`ifdef CITADEL_TAMPER_EN
        tamper    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({unlock, deny, locked_out, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: unlock/deny/locked/busy=%b required 0000",
                     {unlock, deny, locked_out, busy});
        end
        checks++;
        if (fail_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_fail_count: got %0d required 0", fail_count);
        end
        checks++;
        if (key_ready !== 1'b0 || k17_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: key_ready=%b k17_ready=%b required 0", key_ready, k17_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: key_ready=%b busy=%b required 1,0", key_ready, busy);
        end
    endtask

    task automatic test_match();
        attempt(8'hA5, 8'hA5, 10, 0, 1'b0, -1);
        checks++;
        if (tr_unl !== 32'h0000_0078) begin
            errors++;
            $display("FAIL match_unlock: got %h required %h", tr_unl, 32'h0000_0078);
        end
        checks++;
        if (tr_deny !== 32'h0 || tr_lock !== 32'h0) begin
            errors++;
            $display("FAIL match_no_deny: deny=%h lock=%h required 0", tr_deny, tr_lock);
        end
        checks++;
        if (tr_busy !== 32'h0000_007F) begin
            errors++;
            $display("FAIL match_busy: got %h required %h", tr_busy, 32'h0000_007F);
        end
        checks++;
        if (tr_rdy !== 32'h0000_0780) begin
            errors++;
            $display("FAIL match_ready: got %h required %h", tr_rdy, 32'h0000_0780);
        end
        checks++;
        if (fc3 !== 2'd0) begin
            errors++;
            $display("FAIL match_fail_count: got %0d required 0", fc3);
        end
    endtask

    task automatic test_mismatch();
        attempt(8'hA4, 8'hA5, 6, 0, 1'b0, -1);
        checks++;
        if (tr_deny !== 32'h0000_0008) begin
            errors++;
            $display("FAIL mismatch_deny: got %h required %h", tr_deny, 32'h0000_0008);
        end
        checks++;
        if (tr_unl !== 32'h0 || tr_lock !== 32'h0) begin
            errors++;
            $display("FAIL mismatch_no_unlock: unlock=%h lock=%h required 0", tr_unl, tr_lock);
        end
        checks++;
        if (tr_busy !== 32'h0000_000F || tr_rdy !== 32'h0000_0070) begin
            errors++;
            $display("FAIL mismatch_busy_ready: busy=%h ready=%h required 0000000f 00000070", tr_busy, tr_rdy);
        end
        checks++;
        if (fc3 !== 2'd1) begin
            errors++;
            $display("FAIL mismatch_fail_count: got %0d required 1", fc3);
        end
    endtask

    // Continues from one failure: two more mismatches reach the limit.
    task automatic test_lockout();
        attempt(8'h5A, 8'hA5, 6, 0, 1'b0, -1);
        checks++;
        if (fc3 !== 2'd2 || tr_lock !== 32'h0) begin
            errors++;
            $display("FAIL lockout_second: fail_count=%0d lock=%h required 2, 0", fc3, tr_lock);
        end
        // key_valid stays high through lockout and must be ignored.
        attempt(8'h00, 8'hA5, 22, 19, 1'b0, -1);
        checks++;
        if (tr_deny !== 32'h0000_0008 || fc3 !== 2'd3) begin
            errors++;
            $display("FAIL lockout_third_deny: deny=%h fail_count=%0d required 00000008, 3", tr_deny, fc3);
        end
        checks++;
        if (tr_lock !== 32'h000F_FFF0) begin
            errors++;
            $display("FAIL lockout_window: got %h required %h", tr_lock, 32'h000F_FFF0);
        end
        checks++;
        if (tr_busy !== 32'h000F_FFFF || tr_rdy !== 32'h0070_0000) begin
            errors++;
            $display("FAIL lockout_busy_ready: busy=%h ready=%h required 000fffff 00700000", tr_busy, tr_rdy);
        end
        checks++;
        if (fc_mid !== 2'd3 || fc_end !== 2'd0) begin
            errors++;
            $display("FAIL lockout_fail_count: mid=%0d end=%0d required 3, 0", fc_mid, fc_end);
        end
    endtask

    task automatic test_recover();
        attempt(8'h5A, 8'hA5, 6, 0, 1'b0, -1);
        attempt(8'hFF, 8'hA5, 6, 0, 1'b0, -1);
        checks++;
        if (fc3 !== 2'd2) begin
            errors++;
            $display("FAIL recover_two_fails: got %0d required 2", fc3);
        end
        attempt(8'h3C, 8'h3C, 10, 0, 1'b0, -1);
        checks++;
        if (tr_unl !== 32'h0000_0078 || fc3 !== 2'd0) begin
            errors++;
            $display("FAIL recover_grant: unlock=%h fail_count=%0d required 00000078, 0", tr_unl, fc3);
        end
        attempt(8'h3D, 8'h3C, 8, 0, 1'b0, -1);
        checks++;
        if (fc3 !== 2'd1 || tr_lock !== 32'h0 || tr_deny !== 32'h0000_0008) begin
            errors++;
            $display("FAIL recover_single_fail: fail_count=%0d lock=%h deny=%h required 1, 0, 00000008",
                     fc3, tr_lock, tr_deny);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        // Abort a mismatch during CHECK while one failure is recorded.
        attempt(8'h11, 8'h22, 1, 0, 1'b0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fail_count !== 2'd0 || key_ready !== 1'b0 || deny !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_check: busy=%b fail_count=%0d ready=%b deny=%b required 0,0,0,0",
                     busy, fail_count, key_ready, deny);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | deny | busy | unlock;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_residual: got activity=%b required 0", seen);
        end
        // Keys scrambled after accept; then reset in the middle of GRANT.
        attempt(8'hC3, 8'hC3, 4, 0, 1'b1, -1);
        checks++;
        if (tr_unl !== 32'h0000_0018 || tr_deny !== 32'h0) begin
            errors++;
            $display("FAIL capture_on_accept: unlock=%h deny=%h required 00000018, 0", tr_unl, tr_deny);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (unlock !== 1'b0 || busy !== 1'b0 || fail_count !== 2'd0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_grant: unlock=%b busy=%b fail_count=%0d ready=%b required 0,0,0,0",
                     unlock, busy, fail_count, key_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_grant: ready=%b unlock=%b required 1,0", key_ready, unlock);
        end
    endtask

`ifdef CITADEL_TAMPER_EN
    task automatic test_tamper();
        attempt(8'h3C, 8'h3C, 20, 0, 1'b0, 1);
        checks++;
        if (tr_unl !== 32'h0 || tr_deny !== 32'h0) begin
            errors++;
            $display("FAIL tamper_no_unlock: unlock=%h deny=%h required 0", tr_unl, tr_deny);
        end
        checks++;
        if (tr_lock !== 32'h0001_FFFE) begin
            errors++;
            $display("FAIL tamper_lockout: got %h required %h", tr_lock, 32'h0001_FFFE);
        end
        checks++;
        if (fc3 !== 2'd3 || fc_end !== 2'd0) begin
            errors++;
            $display("FAIL tamper_fail_count: mid=%0d end=%0d required 3, 0", fc3, fc_end);
        end
        checks++;
        if (tr_rdy !== 32'h001E_0000) begin
            errors++;
            $display("FAIL tamper_ready: got %h required %h", tr_rdy, 32'h001E_0000);
        end
    endtask
`endif

    task automatic test_width17();
        logic [31:0] t_unl;
        logic [31:0] t_deny;
        logic [16:0] keys [2];
        keys[0] = 17'h1_2345;
        keys[1] = 17'h0_2345;
        for (int a = 0; a < 2; a++) begin
            @(negedge clk);
            checks++;
            if (k17_ready !== 1'b1) begin
                errors++;
                $display("FAIL w17_ready: got %b required 1", k17_ready);
            end
            k17_in    = keys[a];
            k17_ref   = 17'h1_2345;
            k17_valid = 1'b1;
            t_unl     = '0;
            t_deny    = '0;
            for (int i = 0; i <= 9; i++) begin
                @(negedge clk);
                t_unl[i]  = k17_unlock;
                t_deny[i] = k17_deny;
                k17_valid = 1'b0;
            end
            checks++;
            if (a == 0 && (t_unl !== 32'h0000_00F0 || t_deny !== 32'h0)) begin
                errors++;
                $display("FAIL w17_match: unlock=%h deny=%h required 000000f0, 0", t_unl, t_deny);
            end else if (a == 1 && (t_deny !== 32'h0000_0010 || t_unl !== 32'h0)) begin
                errors++;
                $display("FAIL w17_bit16_mismatch: deny=%h unlock=%h required 00000010, 0", t_deny, t_unl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_lockout();
        test_recover();
        test_reset_mid();
`ifdef CITADEL_TAMPER_EN
        test_tamper();
`endif
        test_width17();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
